mc_sequencer: RTL
=================

Name: mc_sequencer

Overview:
- Moore FSM that sequences the shared multi-cycle MIPS datapath (single ALU, single unified memory port) through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Decodes `opcode` from the instruction register and drives every datapath control strobe.
- Waits on a memory-ready handshake and traps to a sticky FAULT state on memory timeout or illegal opcode.

Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles in a memory state before FAULT; range 1..255.
- TMR_W, 8: width of the internal wait counter; must satisfy 2^TMR_W > MEM_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  6  instr[31:26] from the instruction register
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero
- pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  writeback select: 1 = MDR, 0 = ALUOut
- reg_dst  output  1  destination select: 1 = rd, 0 = rt
- reg_write  output  1  register file write
- alu_src_a  output  1  0 = PC, 1 = rs
- alu_src_b  output  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
- alu_op  output  2  to ALUControl: 00 add, 01 sub, 10 funct
- fault  output  1  sticky error flag
- state_o  output  4  current state encoding, for debug
- instr_count  output  32  retired-instruction count; see Optional Feature

Behaviour:
- State encoding (state_o): FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, FAULT=12.
- Reset: on a clk edge with reset=1, state←FETCH, wait counter←0, fault←0, instr_count←0.
  - While reset=1, every control output is 0 (combinational gate) and state_o reads the register value.
  - Reset overrides FAULT and any in-flight memory wait.
- Outputs are Moore decodes of state. Any strobe not listed for a state is 0.
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ready.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEM_RD: mem_read=1, i_or_d=1.
  - MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1.
  - MEM_WR: mem_write=1, i_or_d=1.
  - R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - R_WB: reg_dst=1, mem_to_reg=0, reg_write=1.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1.
  - FAULT: all strobes 0, fault=1.
- Transitions:
  - FETCH→DECODE when mem_ready.
  - DECODE by opcode: 000000→R_EXEC, 100011/101011→MEM_ADDR, 000100→BRANCH, 000010→JUMP, 001000→ADDI_EXEC, any other→FAULT.
  - MEM_ADDR→MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD→MEM_WB when mem_ready.
  - MEM_WR→FETCH when mem_ready.
  - R_EXEC→R_WB; ADDI_EXEC→ADDI_WB.
  - MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP→FETCH.
  - FAULT→FAULT until reset.
- Opcode is sampled in DECODE and in MEM_ADDR only. It must be stable from DECODE through MEM_ADDR because the IR is not written.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle spent in one of these states with mem_ready=0.
  - If the counter equals MEM_TIMEOUT and mem_ready=0, next state is FAULT.
  - mem_ready=1 in the same cycle always wins: normal transition, no fault.
  - Counter saturates and never wraps.
- Cycle counts with mem_ready tied high:
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles.
  - Each additional wait cycle adds exactly 1 cycle.
- Retire event: a one-cycle pulse on the last cycle of each instruction (MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP, or MEM_WR with mem_ready=1).

Optional Feature:
- Macro: MC_SEQ_INSTR_COUNT_EN.
- Defined: instr_count is a 32-bit register incremented by 1 on each retire event. It wraps 0xFFFFFFFF→0, is cleared by reset, and holds in FAULT.
- Undefined: no counter logic is built; instr_count is tied to 32'h0.
- The port list is identical in both builds.

Test Plan:
- Reset then release, mem_ready=1, opcode=000000: state_o 0,1,6,7,0. reg_write=1 and reg_dst=1 only in state 7. alu_op=10 in state 6.
- opcode=100011, mem_ready low for 3 cycles in MEM_RD: lw takes 8 cycles total. mem_read=1, i_or_d=1 held throughout MEM_RD. MEM_WB has mem_to_reg=1.
- opcode=000100 then 000010, mem_ready=1: BRANCH asserts pc_write_cond=1, pc_source=01, alu_op=01. JUMP asserts pc_write=1, pc_source=10. Each instruction takes 3 cycles.
- opcode=111111 at DECODE: state_o=12 next cycle. fault=1 and all strobes 0 held for 20 cycles. Reset pulse returns state_o=0 and fault=0.
- MEM_TIMEOUT=15, mem_ready=0 in FETCH: FAULT entered after the 16th FETCH cycle. Repeat with mem_ready=1 exactly on that cycle: DECODE is entered and fault stays 0.
- With MC_SEQ_INSTR_COUNT_EN, execute addi, sw, beq, j, then assert reset mid-lw in MEM_RD: instr_count=4 before reset, 0 after reset. Without the macro, instr_count=0 throughout.

Source files
------------

// File: rtl/mc_sequencer.sv
// mc_sequencer: Moore control FSM for a shared multi-cycle MIPS datapath.
// Steps the single ALU and the unified memory port through
// FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK. It waits on mem_ready in
// the memory states and traps to a sticky FAULT state on a memory timeout
// or on an illegal opcode.
// Optional build macro MC_SEQ_INSTR_COUNT_EN adds a 32-bit retired-instruction
// counter. Without the macro, instr_count is tied to zero.
module mc_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_source,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        fault,
  output logic [3:0]  state_o,
  output logic [31:0] instr_count
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_RD    = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WR    = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;
  localparam logic [3:0] S_FAULT     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [TMR_W-1:0] LP_TIMEOUT = TMR_W'(MEM_TIMEOUT);
  localparam logic [TMR_W-1:0] LP_ONE     = TMR_W'(1);

  logic [3:0]       r_state;
  logic [TMR_W-1:0] r_wait;
  logic [3:0]       w_next;
  logic             w_timeout;
  logic             w_wait_state;

  // Memory-wait states are the only ones that spend time on mem_ready.
  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                        (r_state == S_MEM_WR);
  // Timeout triggers only if memory is still not ready. A ready in the same
  // cycle always wins.
  assign w_timeout    = (r_wait == LP_TIMEOUT) && !mem_ready;

  // Next-state logic. Opcode is consulted only in DECODE and MEM_ADDR.
  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = S_R_EXEC;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDI_EXEC;
          default:      w_next = S_FAULT;
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      w_next = S_MEM_RD;
        else if (opcode == OP_SW) w_next = S_MEM_WR;
        else                      w_next = S_FAULT;  // opcode changed under us
      end
      S_MEM_RD: begin
        if (mem_ready)      w_next = S_MEM_WB;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_MEM_WR: begin
        if (mem_ready)      w_next = S_FETCH;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_R_EXEC:    w_next = S_R_WB;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: w_next = S_FETCH;
      S_FAULT:     w_next = S_FAULT;
      default:     w_next = S_FAULT;
    endcase
  end

  // State register. Reset overrides FAULT and any in-flight wait.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Wait counter: cleared on every state change (which covers entry to a
  // wait state), counts idle cycles inside a wait state, and saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait <= '0;
    end else if (w_next != r_state) begin
      r_wait <= '0;
    end else if (w_wait_state && !mem_ready && (r_wait != '1)) begin
      r_wait <= r_wait + LP_ONE;
    end
  end

  // Moore output decode, gated to all-zero while reset is held.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    fault         = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:    alu_src_b = 2'b11;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_R_WB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDI_WB:   reg_write = 1'b1;
        S_FAULT:     fault     = 1'b1;
        default:     fault     = 1'b1;
      endcase
    end
  end

  assign state_o = r_state;

`ifdef MC_SEQ_INSTR_COUNT_EN
  logic        w_retire;
  logic [31:0] r_instr_count;

  // Last cycle of each instruction. A store retires only when memory accepts it.
  assign w_retire = (r_state == S_MEM_WB) || (r_state == S_R_WB) ||
                    (r_state == S_ADDI_WB) || (r_state == S_BRANCH) ||
                    (r_state == S_JUMP) || ((r_state == S_MEM_WR) && mem_ready);

  // Retired-instruction counter. It wraps naturally and holds in FAULT because nothing retires there.
  always_ff @(posedge clk) begin
    if (reset)         r_instr_count <= 32'h0;
    else if (w_retire) r_instr_count <= r_instr_count + 32'd1;
  end

  assign instr_count = r_instr_count;
`else
  assign instr_count = 32'h0;
`endif

endmodule
